// File: rtl/dmem_bus_if_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_if_if
// Core-side request/response bundle for the data-memory bus bridge.
//
// Signals:
//   req    core access request (sampled by the bridge only while busy=0)
//   we     1=store, 0=load
//   size   00=word, 01=halfword, 10/11=byte
//   uns    1=zero-extend sub-word loads, 0=sign-extend
//   addr   byte address
//   wdata  right-aligned store data
//   busy   access in flight; the core stalls while it is 1
//   done   one-cycle pulse on successful completion
//   err    one-cycle pulse on misalignment or bus timeout
//   rdata  extended load result, held until the next completed load
//
// Modports:
//   master  the core (drives the request fields)
//   slave   the bridge (drives busy/done/err/rdata)
// -----------------------------------------------------------------------------
interface dmem_bus_if_if #(
  parameter int BIT_WIDTH = 32
) ();
  logic                 req;
  logic                 we;
  logic [1:0]           size;
  logic                 uns;
  logic [BIT_WIDTH-1:0] addr;
  logic [BIT_WIDTH-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [BIT_WIDTH-1:0] rdata;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/dmem_bus_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_if
// Bridges single core load/store requests onto an external data bus with a
// bidirectional data path and an active-low acknowledge.
//
// Ports:
//   clk     single clock, rising edge
//   rst     asynchronous, active-low reset
//   core    core-side request/response bundle (slave modport)
//   DAD     bus address (registered request address)
//   MREQ    bus request, high for the whole ACCESS phase
//   WRITE   bus direction, 1=write
//   SIZE    bus access size, same encoding as the core size field
//   ACKD_n  bus acknowledge, active-low, only looked at during ACCESS
//   DDT     bidirectional data; driven only while a store is in ACCESS
//
// Flow: IDLE accepts a request (misaligned ones pulse err and stay in IDLE),
// ACCESS waits for ACKD_n=0 or the wait counter to run out, FINISH pulses done
// for one cycle and returns to IDLE.
// -----------------------------------------------------------------------------
module dmem_bus_if #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_if_if.slave         core,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last count value before the abort: the abort fires on the edge that would
  // make the counter reach TIMEOUT-1.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q,  addr_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic                 we_q,    we_d;
  logic                 uns_q,   uns_d;
  logic [1:0]           size_q,  size_d;
  logic                 err_q,   err_d;
  logic [CNT_W-1:0]     wait_q,  wait_d;

  logic                 misaligned;
  logic [BIT_WIDTH-1:0] store_word;
  logic [BIT_WIDTH-1:0] load_word;
  logic                 ddt_oe;

  // Alignment is judged on the live request fields, since that is the cycle
  // the request gets accepted or rejected.
  always_comb begin
    misaligned = 1'b0;
    if (core.size == 2'b00)      misaligned = |core.addr[1:0];
    else if (core.size == 2'b01) misaligned = core.addr[0];
  end

  // Store data is zero-padded to the bus width; size 11 behaves as a byte.
  always_comb begin
    store_word = {{(BIT_WIDTH-8){1'b0}}, wdata_q[7:0]};
    if (size_q == 2'b00)      store_word = wdata_q;
    else if (size_q == 2'b01) store_word = {{(BIT_WIDTH-16){1'b0}}, wdata_q[15:0]};
  end

  // Load data is extended from the low lanes of the bus.
  always_comb begin
    load_word = {{(BIT_WIDTH-8){DDT[7] & ~uns_q}}, DDT[7:0]};
    if (size_q == 2'b00)      load_word = DDT;
    else if (size_q == 2'b01) load_word = {{(BIT_WIDTH-16){DDT[15] & ~uns_q}}, DDT[15:0]};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    wait_d  = wait_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (core.req) begin
          addr_d  = core.addr;
          wdata_d = core.wdata;
          we_d    = core.we;
          uns_d   = core.uns;
          size_d  = core.size;
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
            wait_d  = '0;
          end
        end
      end
      S_ACCESS: begin
        // An acknowledge on the very cycle the counter runs out still wins.
        if (!ACKD_n) begin
          state_d = S_FINISH;
          if (!we_q) rdata_d = load_word;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wait_d  = wait_q + 1'b1;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // All bus outputs decode straight from flops, so an asynchronous reset
  // drops MREQ and releases DDT without waiting for a clock edge.
  assign MREQ   = (state_q == S_ACCESS);
  assign DAD    = addr_q;
  assign WRITE  = we_q;
  assign SIZE   = size_q;
  assign ddt_oe = MREQ && we_q;
  assign DDT    = ddt_oe ? store_word : {BIT_WIDTH{1'bz}};

  assign core.busy  = (state_q != S_IDLE);
  assign core.done  = (state_q == S_FINISH);
  assign core.err   = err_q;
  assign core.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_if
// Randomized bench for dmem_bus_if. A driver issues core requests and pushes
// the expected core response into a scoreboard queue and the expected bus
// behaviour into a bus queue; a memory responder plays the bus slave and
// checks the bus side; a monitor pops the scoreboard on every done/err.
// -----------------------------------------------------------------------------
module tb_dmem_bus_if;
  localparam int W   = 32;
  localparam int TMO = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] dad;
  logic         mreq;
  logic         write;
  logic [1:0]   bsize;
  logic         ackd_n;
  wire  [W-1:0] ddt;
  logic         mem_drv;
  logic [W-1:0] mem_val;

  assign ddt = mem_drv ? mem_val : {W{1'bz}};

  dmem_bus_if_if #(.BIT_WIDTH(W)) core_if ();

  dmem_bus_if #(.BIT_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rst    (rst),
    .core   (core_if),
    .DAD    (dad),
    .MREQ   (mreq),
    .WRITE  (write),
    .SIZE   (bsize),
    .ACKD_n (ackd_n),
    .DDT    (ddt)
  );

  always #5 clk = ~clk;

  // delay >= 0 : ack after delay+1 MREQ cycles; -1 : never ack (timeout);
  // -2 : transfer will be killed by reset (no core response expected)
  typedef struct {
    bit           is_err;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    bit           we;
    logic [1:0]   size;
    logic [W-1:0] addr;
    logic [W-1:0] ddt;
    int           delay;
    logic [W-1:0] mem_data;
  } bus_t;

  exp_t         sb_q[$];
  bus_t         bus_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] model_rdata;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A released bus reads as z (4-state) or 0 (2-state); a driven one shows 1s.
  task automatic check_released(input string name);
    tests++;
    if ((|ddt) === 1'b1) begin
      fails++;
      $display("FAIL %s: DDT=%h, expected released", name, ddt);
    end
  endtask

  function automatic logic [W-1:0] load_value(input logic [W-1:0] d, input logic [1:0] sz, input bit uns);
    logic [W-1:0] v;
    if (sz == 2'b00) return d;
    if (sz == 2'b01) begin
      v = d % 32'h1_0000;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = d % 32'h100;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] store_value(input logic [W-1:0] d, input logic [1:0] sz);
    if (sz == 2'b00) return d;
    if (sz == 2'b01) return d % 32'h1_0000;
    return d % 32'h100;
  endfunction

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata, input int delay, input logic [W-1:0] mem_data);
    int   guard;
    bit   mis;
    exp_t e;
    bus_t b;
    guard = 0;
    // While busy, wiggle the request inputs: the bridge must ignore them.
    while (core_if.busy !== 1'b0) begin
      core_if.req   = 1'($urandom_range(0, 1));
      core_if.we    = 1'($urandom_range(0, 1));
      core_if.size  = 2'($urandom_range(0, 3));
      core_if.uns   = 1'($urandom_range(0, 1));
      core_if.addr  = $urandom();
      core_if.wdata = $urandom();
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        tests++;
        fails++;
        $display("FAIL busy_wait: busy still %b after %0d cycles, required 0", core_if.busy, guard);
        core_if.req = 1'b0;
        return;
      end
    end
    mis = (sz == 2'b00 && addr % 4 != 0) || (sz == 2'b01 && addr % 2 != 0);
    e.is_err = mis || (delay == -1);
    if (!mis && !we && delay >= 0) model_rdata = load_value(mem_data, sz, uns);
    e.rdata = model_rdata;
    if (delay != -2) sb_q.push_back(e);
    if (!mis) begin
      b.we = we; b.size = sz; b.addr = addr; b.ddt = store_value(wdata, sz);
      b.delay = delay; b.mem_data = mem_data;
      bus_q.push_back(b);
    end
    $display("[TB] tx %s size=%0d uns=%0d addr=%h wdata=%h delay=%0d mem=%h misaligned=%0d",
             we ? "ST" : "LD", sz, uns, addr, wdata, delay, mem_data, mis);
    core_if.req   = 1'b1;
    core_if.we    = we;
    core_if.size  = sz;
    core_if.uns   = uns;
    core_if.addr  = addr;
    core_if.wdata = wdata;
    @(negedge clk);
    core_if.req = 1'b0;
    if (mis) begin
      check("misalign_busy", {31'b0, core_if.busy}, 32'd0);
      check("misalign_mreq", {31'b0, mreq}, 32'd0);
    end
  endtask

  // Memory responder: checks the bus side and supplies acknowledges/data.
  initial begin
    int   c;
    bus_t cur;
    bit   active;
    active = 1'b0; c = 0; ackd_n = 1'b1; mem_drv = 1'b0; mem_val = '0;
    cur = '{we: 1'b0, size: 2'b00, addr: '0, ddt: '0, delay: 0, mem_data: '0};
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        active = 1'b0; c = 0; ackd_n = 1'b1; mem_drv = 1'b0;
      end else if (mreq) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_mreq: MREQ=1 with no transfer outstanding, required 0");
            cur = '{we: write, size: bsize, addr: dad, ddt: ddt, delay: 0, mem_data: '0};
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1'b1;
          c = 0;
        end
        c++;
        check("bus_dad", dad, cur.addr);
        check("bus_write", {31'b0, write}, {31'b0, cur.we});
        check("bus_size", {30'b0, bsize}, {30'b0, cur.size});
        if (cur.we) check("store_ddt", ddt, cur.ddt);
        if (cur.delay >= 0 && c == cur.delay + 1) begin
          ackd_n = 1'b0;
          if (!cur.we) begin
            mem_drv = 1'b1;
            mem_val = cur.mem_data;
          end
        end else begin
          ackd_n = 1'b1;
        end
      end else begin
        mem_drv = 1'b0;
        if (active) begin
          if (cur.we) check_released("store_release");
          if (cur.delay >= 0) check("mreq_cycles", c, cur.delay + 1);
          else if (cur.delay == -1) check("timeout_cycles", c, TMO - 1);
          active = 1'b0;
        end
        // Acknowledges outside ACCESS must have no effect.
        ackd_n = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every done/err pulse must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (core_if.done === 1'b1 || core_if.err === 1'b1)) begin
        check("done_err_exclusive", {31'b0, core_if.done & core_if.err}, 32'd0);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: done=%b err=%b with nothing outstanding", core_if.done, core_if.err);
        end else begin
          e = sb_q.pop_front();
          check("resp_kind_err", {31'b0, core_if.err}, {31'b0, e.is_err});
          check("resp_rdata", core_if.rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           r_we, r_uns;
    logic [1:0]   r_sz, lo;
    logic [W-1:0] r_addr, r_wdata, r_mem;
    int           r_delay, g;

    rst = 1'b0;
    model_rdata = '0;
    core_if.req = 1'b0; core_if.we = 1'b0; core_if.size = 2'b00; core_if.uns = 1'b0;
    core_if.addr = '0; core_if.wdata = '0;
    #1;
    check("rst_mreq",  {31'b0, mreq}, 32'd0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_dad",   dad, 32'd0);
    check("rst_size",  {30'b0, bsize}, 32'd0);
    check("rst_busy",  {31'b0, core_if.busy}, 32'd0);
    check("rst_done",  {31'b0, core_if.done}, 32'd0);
    check("rst_err",   {31'b0, core_if.err}, 32'd0);
    check("rst_rdata", core_if.rdata, 32'd0);
    check_released("rst_ddt");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0000, 32'h0, 0, 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0, 1, 32'h0000_0080);
    issue(1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0, 2, 32'h0000_0080);
    issue(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAABB_CC41, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h0800_0001, 32'h0, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0, 3, 32'h5555_9ABC);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, -1, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0203, 32'h1111_22F3, 1, 32'h0);

    for (int i = 0; i < 120; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom_range(0, 1));
      lo    = 2'($urandom_range(0, 3));
      if (r_sz < 2'b10 && $urandom_range(0, 3) != 0) lo = 2'b00;
      r_addr  = ($urandom() & 32'hFFFF_FFFC) | {30'b0, lo};
      r_wdata = $urandom() | 32'h1;
      r_delay = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 4));
      r_mem   = $urandom();
      issue(r_we, r_sz, r_uns, r_addr, r_wdata, r_delay, r_mem);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a store
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, -2, 32'h0);
    check("pre_rst_mreq", {31'b0, mreq}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_mreq",  {31'b0, mreq}, 32'd0);
    check("midrst_busy",  {31'b0, core_if.busy}, 32'd0);
    check("midrst_done",  {31'b0, core_if.done}, 32'd0);
    check("midrst_err",   {31'b0, core_if.err}, 32'd0);
    check("midrst_rdata", core_if.rdata, 32'd0);
    check("midrst_dad",   dad, 32'd0);
    check_released("midrst_ddt");
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 30; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_sz    = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = $urandom();
      r_wdata = $urandom() | 32'h1;
      r_mem   = $urandom();
      issue(r_we, r_sz, r_uns, r_addr, r_wdata, int'($urandom_range(0, 3)), r_mem);
    end

    core_if.req = 1'b0;
    g = 0;
    while ((sb_q.size() != 0 || core_if.busy !== 1'b0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (g >= 600) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses still outstanding, required 0", sb_q.size());
    end
    @(negedge clk);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
